// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Sweeps every input vector of a small combinational function block. Each
// vector is held SETTLE+1 cycles, and the block's output is sampled into a
// captured truth table. The captured table is compared against an expected
// table latched at start. The results are a pass flag, a mismatch count and
// the lowest failing vector.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request a sweep (accepted only when idle)
//   abort        synchronous cancel of a running sweep
//   expected     expected table, bit i = expected output for vector i
//   s_in         output of the function block under control
//   xy_out       function block inputs (MSB = x, LSB = y for N=2)
//   vec_valid    xy_out holds a vector being evaluated
//   busy         sweep in progress or completing
//   done         one-cycle pulse at sweep completion
//   truth_table  captured outputs, bit i = s_in sampled for vector i
//   pass         last completed sweep had zero mismatches
//   err_count    number of mismatching vectors
//   first_err    index of lowest mismatching vector (0 if none)
module truth_table_sequencer #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2**N-1:0] expected,
  input  logic            s_in,
  output logic [N-1:0]    xy_out,
  output logic            vec_valid,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] truth_table,
  output logic            pass,
  output logic [N:0]      err_count,
  output logic [N-1:0]    first_err
);

  localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
  localparam logic [N-1:0] IDX_ONE  = N'(1'b1);
  localparam logic [N:0]   ERR_ONE  = (N+1)'(1'b1);
  localparam logic [N:0]   ERR_ZERO = {(N+1){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [N-1:0]    index, index_next;
  logic [3:0]      cnt, cnt_next;
  logic [2**N-1:0] exp_q, exp_next;
  logic [2**N-1:0] table_next;
  logic [N:0]      err_next;
  logic [N-1:0]    first_next;
  logic            pass_next;
  logic [N-1:0]    xy_next;
  logic            vec_valid_next;
  logic            busy_next;
  logic            done_next;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_next = state;
    index_next = index;
    cnt_next   = cnt;
    exp_next   = exp_q;
    table_next = truth_table;
    err_next   = err_count;
    first_next = first_err;
    pass_next  = pass;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = HOLD;
          exp_next   = expected;
          table_next = '0;
          err_next   = ERR_ZERO;
          first_next = '0;
          pass_next  = 1'b0;
          index_next = '0;
          cnt_next   = 4'd0;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        // Abort wins over a sample falling on the same edge.
        if (abort) begin
          state_next = IDLE;
          index_next = '0;
          cnt_next   = 4'd0;
        end else if (cnt != SETTLE_C) begin
          cnt_next = cnt + 4'd1;
        end else begin
          table_next[index] = s_in;
          if (s_in != exp_q[index]) begin
            err_next = err_count + ERR_ONE;
            if (err_count == ERR_ZERO) begin
              first_next = index;
            end else begin
              first_next = first_err;
            end
          end else begin
            err_next = err_count;
          end
          cnt_next = 4'd0;
          if (index == IDX_LAST) begin
            state_next = DONE;
            index_next = '0;
            // Uses the count including this final sample so pass is valid in DONE.
            pass_next  = (err_next == ERR_ZERO);
          end else begin
            index_next = index + IDX_ONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
        cnt_next   = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered.
    if (state_next == HOLD) begin
      xy_next        = index_next;
      vec_valid_next = 1'b1;
    end else begin
      xy_next        = '0;
      vec_valid_next = 1'b0;
    end
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      index       <= '0;
      cnt         <= 4'd0;
      exp_q       <= '0;
      truth_table <= '0;
      err_count   <= ERR_ZERO;
      first_err   <= '0;
      pass        <= 1'b0;
      xy_out      <= '0;
      vec_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      index       <= index_next;
      cnt         <= cnt_next;
      exp_q       <= exp_next;
      truth_table <= table_next;
      err_count   <= err_next;
      first_err   <= first_next;
      pass        <= pass_next;
      xy_out      <= xy_next;
      vec_valid   <= vec_valid_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that exercises a small combinational function block (the two-input x/y logic functions in this lab set) by sweeping every input combination, holding each long enough to settle, and sampling the block's output into a truth-table register. It compares the captured table against an expected table and reports pass/fail, error count and the first failing vector. It sits between a start/done control interface and the function block's inputs and output.

## Interface
- N, default 2: number of function inputs (1..4); vector index width.
- SETTLE, default 1: extra hold cycles per vector before sampling (0..15).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a sweep; accepted only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- expected  in  2^N  expected table; bit i = expected output for input vector i.
- s_in  in  1  output of the function block under control.
- xy_out  out  N  drives the function inputs; MSB = x, LSB = y for N=2.
- vec_valid  out  1  high while xy_out holds a vector being evaluated.
- busy  out  1  high in HOLD and DONE.
- done  out  1  one-cycle pulse at sweep completion.
- table  out  2^N  captured outputs; bit i = s_in sampled for vector i.
- pass  out  1  high when last completed sweep had zero mismatches.
- err_count  out  N+1  number of mismatching vectors.
- first_err  out  N  index of lowest mismatching vector (0 if none).

## Operation
- States: IDLE, HOLD, DONE.
- IDLE: xy_out=0, vec_valid=0, busy=0. On start=1 at a clock edge: latch expected into internal exp_q, clear table, err_count, first_err, pass; index=0, hold counter=0; go HOLD.
- HOLD: xy_out=index, vec_valid=1, busy=1. Each edge: if counter<SETTLE, counter++. If counter==SETTLE: table[index]<=s_in; if s_in!=exp_q[index], err_count++ and, when err_count was 0, first_err<=index; counter<=0; if index==2^N-1 go DONE, else index++.
- DONE: one cycle; done=1, busy=1, vec_valid=0, xy_out=0; pass<=(err_count==0) registered on entry so valid in this cycle; next edge to IDLE.
- abort=1 in HOLD: next edge to IDLE; no done pulse; pass stays 0; table/err_count keep partial values. abort ignored in IDLE/DONE. abort has priority over the sample on the same edge (sample discarded).
- start while busy (HOLD or DONE) ignored; expected changes after acceptance have no effect.
- table, err_count, first_err, pass hold their values in IDLE until the next accepted start.
- err_count width N+1 so 2^N mismatches never wraps.

## Timing
- Reset (asynchronous, immediate, no clock needed): state IDLE; xy_out=0, vec_valid=0, busy=0, done=0, table=0, pass=0, err_count=0, first_err=0; index and counter 0. Reset mid-sweep discards everything.
- Each vector held SETTLE+1 cycles; s_in sampled at the edge ending the vector's last cycle.
- Start accepted at edge E0; vector 0 appears in the cycle after E0. done high in cycle 2^N*(SETTLE+1)+1 after E0 (N=2, SETTLE=1: cycle 9).
- Earliest restart: start high during the cycle after DONE (IDLE) is accepted; back-to-back sweeps are separated by exactly one IDLE cycle.
- s_in is assumed combinationally derived from xy_out; no input synchronisation.

## Test plan
- NOR block (s = ~x & ~y), N=2, SETTLE=1, expected=4'b0001, pulse start -> xy_out steps 00,01,10,11 for 2 cycles each; done in cycle 9; table=4'b0001, err_count=0, pass=1.
- Same block, expected=4'b1000 -> table=4'b0001, err_count=2, first_err=0, pass=0, done in cycle 9.
- start re-pulsed in cycles 3 and 9 of a run -> ignored; exactly one done; results unchanged; start in following IDLE cycle launches a new sweep.
- abort asserted in cycle 4 -> IDLE next edge, vec_valid=0, busy=0, no done, pass=0; next start completes normally with pass=1.
- reset raised mid-sweep between clock edges -> all outputs 0 immediately; after release, start runs a full correct sweep.
- SETTLE=0, start held high continuously -> 1 cycle per vector, done in cycle 5, one IDLE cycle, second sweep starts automatically with identical results.
